// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight destination registers, raises stalls
// and selects forwarding sources for the two ID-stage operands.
module hazard_scoreboard #(
    parameter int REG_FILE_ADDR_LEN  = 5,
    parameter int DEPTH              = 2,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int CNT_LEN            = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1_ID,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2_ID,
    input  logic                         src2_used,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_ID,
    input  logic                         WB_EN_ID,
    input  logic                         MEM_R_EN_ID,
    input  logic                         forward_EN,
    input  logic                         flush,
    input  logic                         clr_cnt,
    output logic                         hazard_detected,
    output logic [$clog2(DEPTH+1)-1:0]   val1_sel,
    output logic [$clog2(DEPTH+1)-1:0]   val2_sel,
    output logic [CNT_LEN-1:0]           stall_cnt
);

    localparam int SEL_W = $clog2(DEPTH+1);

    logic [REG_FILE_ADDR_LEN-1:0] dest_r [DEPTH:1];
    logic [DEPTH:1]               wb_en_r;
    logic [DEPTH:1]               mem_r_en_r;
    logic [CNT_LEN-1:0]           stall_cnt_r;

    logic [DEPTH:1]               match1_s;
    logic [DEPTH:1]               match2_s;
    logic                         hazard_s;
    logic [SEL_W-1:0]             val1_sel_s;
    logic [SEL_W-1:0]             val2_sel_s;

    // A source that is register 0 never participates when it is hardwired.
    function automatic logic src_live(input logic [REG_FILE_ADDR_LEN-1:0] src);
        return (ZERO_REG_HARDWIRED == 0) || (src != '0);
    endfunction

    // Per-entry operand match against the in-flight destinations.
    always_comb begin
        match1_s = '0;
        match2_s = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match1_s[k] = id_valid && wb_en_r[k] && (src1_ID == dest_r[k])
                          && src_live(src1_ID);
            match2_s[k] = id_valid && wb_en_r[k] && src2_used
                          && (src2_ID == dest_r[k]) && src_live(src2_ID);
        end
    end

    // Stall decision and youngest-producer forwarding select.
    always_comb begin
        hazard_s   = 1'b0;
        val1_sel_s = '0;
        val2_sel_s = '0;
        if (forward_EN) begin
            hazard_s = (match1_s[1] || match2_s[1]) && mem_r_en_r[1];
        end else begin
            hazard_s = |{match1_s, match2_s};
        end
        if (forward_EN && !hazard_s) begin
            // Walk oldest to youngest so the youngest match overwrites.
            for (int k = DEPTH; k >= 1; k--) begin
                if (match1_s[k]) begin
                    val1_sel_s = SEL_W'(k);
                end else begin
                    val1_sel_s = val1_sel_s;
                end
                if (match2_s[k]) begin
                    val2_sel_s = SEL_W'(k);
                end else begin
                    val2_sel_s = val2_sel_s;
                end
            end
        end else begin
            val1_sel_s = '0;
            val2_sel_s = '0;
        end
    end

    // In-flight entry pipeline; stalled or flushed ID instructions enter as bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                dest_r[k] <= '0;
            end
            wb_en_r    <= '0;
            mem_r_en_r <= '0;
        end else begin
            if (id_valid && !hazard_s && !flush) begin
                dest_r[1]     <= dest_ID;
                wb_en_r[1]    <= WB_EN_ID;
                mem_r_en_r[1] <= MEM_R_EN_ID;
            end else begin
                dest_r[1]     <= '0;
                wb_en_r[1]    <= 1'b0;
                mem_r_en_r[1] <= 1'b0;
            end
            for (int k = 2; k <= DEPTH; k++) begin
                dest_r[k]     <= dest_r[k-1];
                wb_en_r[k]    <= wb_en_r[k-1];
                mem_r_en_r[k] <= mem_r_en_r[k-1];
            end
        end
    end

    // Saturating stall counter; clear takes priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
        end else if (clr_cnt) begin
            stall_cnt_r <= '0;
        end else if (hazard_s && (stall_cnt_r != {CNT_LEN{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_LEN'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hazard_detected = hazard_s;
    assign val1_sel        = val1_sel_s;
    assign val2_sel        = val2_sel_s;
    assign stall_cnt       = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=2, CNT_LEN=4).
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] src1_ID;
    logic [4:0] src2_ID;
    logic       src2_used;
    logic [4:0] dest_ID;
    logic       WB_EN_ID;
    logic       MEM_R_EN_ID;
    logic       forward_EN;
    logic       flush;
    logic       clr_cnt;
    logic       hazard_detected;
    logic [1:0] val1_sel;
    logic [1:0] val2_sel;
    logic [3:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard #(
        .REG_FILE_ADDR_LEN(5),
        .DEPTH(2),
        .ZERO_REG_HARDWIRED(1),
        .CNT_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .src1_ID(src1_ID),
        .src2_ID(src2_ID),
        .src2_used(src2_used),
        .dest_ID(dest_ID),
        .WB_EN_ID(WB_EN_ID),
        .MEM_R_EN_ID(MEM_R_EN_ID),
        .forward_EN(forward_EN),
        .flush(flush),
        .clr_cnt(clr_cnt),
        .hazard_detected(hazard_detected),
        .val1_sel(val1_sel),
        .val2_sel(val2_sel),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                          input logic su, input logic [4:0] d, input logic wb, input logic ld);
        id_valid    = v;
        src1_ID     = s1;
        src2_ID     = s2;
        src2_used   = su;
        dest_ID     = d;
        WB_EN_ID    = wb;
        MEM_R_EN_ID = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush   = 1'b0;
        clr_cnt = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst        = 1'b0;
        forward_EN = 1'b1;
        flush      = 1'b0;
        clr_cnt    = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset state with hazard-looking ID inputs
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
        #1;
        check_val("rst_hazard", 32'(hazard_detected), 32'd0);
        check_val("rst_v1", 32'(val1_sel), 32'd0);
        check_val("rst_v2", 32'(val2_sel), 32'd0);
        check_val("rst_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b1;
        idle();

        // No forwarding: ADD r3 then reader of r3 stalls 2 cycles
        forward_EN = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        #1;
        check_val("nofwd_issue", 32'(hazard_detected), 32'd0);
        tick();
        set_id(1'b1, 5'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        check_val("nofwd_stall1", 32'(hazard_detected), 32'd1);
        tick();
        check_val("nofwd_stall2", 32'(hazard_detected), 32'd1);
        check_val("nofwd_cnt1", 32'(stall_cnt), 32'd1);
        tick();
        check_val("nofwd_release", 32'(hazard_detected), 32'd0);
        check_val("nofwd_cnt2", 32'(stall_cnt), 32'd2);
        idle();

        // Forwarding from EXE then MEM on src2
        forward_EN = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 5'd6, 1'b0, 1'b0);
        #1;
        check_val("fwd_hazard", 32'(hazard_detected), 32'd0);
        check_val("fwd_v2_exe", 32'(val2_sel), 32'd1);
        check_val("fwd_v1_none", 32'(val1_sel), 32'd0);
        tick();
        check_val("fwd_v2_mem", 32'(val2_sel), 32'd2);
        src2_used = 1'b0;
        #1;
        check_val("fwd_v2_unused", 32'(val2_sel), 32'd0);
        idle();

        // Load-use: one stall then forward from MEM
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 5'd2, 1'b0, 5'd8, 1'b0, 1'b0);
        #1;
        check_val("ld_use_stall", 32'(hazard_detected), 32'd1);
        check_val("ld_use_v1_held", 32'(val1_sel), 32'd0);
        tick();
        check_val("ld_use_release", 32'(hazard_detected), 32'd0);
        check_val("ld_use_v1_mem", 32'(val1_sel), 32'd2);
        check_val("ld_use_cnt", 32'(stall_cnt), 32'd3);
        idle();

        // Register 0 never hazards or forwards
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
        #1;
        check_val("r0_hazard", 32'(hazard_detected), 32'd0);
        check_val("r0_v1", 32'(val1_sel), 32'd0);
        check_val("r0_v2", 32'(val2_sel), 32'd0);
        forward_EN = 1'b0;
        #1;
        check_val("r0_nofwd_hazard", 32'(hazard_detected), 32'd0);
        idle();

        // Youngest producer wins when EXE and MEM both write r9
        forward_EN = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd9, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0);
        #1;
        check_val("youngest_v1", 32'(val1_sel), 32'd1);
        check_val("youngest_hazard", 32'(hazard_detected), 32'd0);
        idle();

        // Flushed producer leaves no trace
        forward_EN = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_id(1'b1, 5'd10, 5'd2, 1'b0, 5'd11, 1'b0, 1'b0);
        #1;
        check_val("flush_no_hazard", 32'(hazard_detected), 32'd0);
        idle();

        // Saturation: constant self-dependent ID gives 2 stalls out of every 3 cycles
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check_val("clr_cnt_zero", 32'(stall_cnt), 32'd0);
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
        repeat (31) tick();
        check_val("sat_hazard", 32'(hazard_detected), 32'd1);
        check_val("sat_cnt", 32'(stall_cnt), 32'd15);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check_val("clr_wins_cnt", 32'(stall_cnt), 32'd0);
        check_val("clr_wins_hazard", 32'(hazard_detected), 32'd1);
        tick();
        check_val("restart_cnt", 32'(stall_cnt), 32'd1);
        check_val("restart_gap", 32'(hazard_detected), 32'd0);
        tick();
        check_val("mid_stall", 32'(hazard_detected), 32'd1);

        // Asynchronous reset mid-stall
        rst = 1'b0;
        #1;
        check_val("async_rst_hazard", 32'(hazard_detected), 32'd0);
        check_val("async_rst_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b1;
        #1;
        check_val("post_rst_hazard", 32'(hazard_detected), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
